// File: rtl/soc_debug_ctrl_if.sv
// AXI4-Lite channel bundle between the interconnect and the debug controller.
// The slave side is the debug controller; the master side is the host or testbench.
interface soc_debug_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/soc_debug_ctrl.sv
// AXI4-Lite debug slave for the rv32i core: halt/resume/step control, PC readback
// and a register-file window with byte-strobe writes done as read-modify-write.
module soc_debug_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int REG_BASE       = 'h200,
    parameter int STEP_CNT_W     = 16,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    soc_debug_ctrl_if.slave           s_axi,
    output logic                      cpu_halt,
    input  logic                      cpu_halted,
    output logic                      cpu_step,
    input  logic [DATA_WIDTH-1:0]     cpu_pc,
    output logic [REG_ADDR_WIDTH-1:0] regfile_addr,
    input  logic [DATA_WIDTH-1:0]     regfile_read_data,
    output logic                      regfile_write_enable,
    output logic [DATA_WIDTH-1:0]     regfile_write_data
);
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int DW     = DATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int RAW    = REG_ADDR_WIDTH;

    localparam logic [AW-1:0] BASE = AW'(REG_BASE);
    localparam logic [AW-1:0] NREG = AW'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] W_MERGE  = 3'd1;
    localparam logic [2:0] W_COMMIT = 3'd2;
    localparam logic [2:0] B_RESP   = 3'd3;
    localparam logic [2:0] R_DATA   = 3'd4;

    typedef struct packed {
        logic           csr;
        logic           win;
        logic [1:0]     sel;
        logic [RAW-1:0] idx;
    } dec_t;

    // csr: aligned hit in the 16-byte CSR block; win: aligned hit on an existing register
    function automatic dec_t decode(input logic [AW-1:0] a);
        dec_t          d;
        logic [AW-1:0] off;
        off   = a - BASE;
        d.csr = (a[1:0] == 2'b00) && ((a >> 4) == '0);
        d.win = (a[1:0] == 2'b00) && (a >= BASE) && ((off >> 2) < NREG);
        d.sel = a[3:2];
        d.idx = off[2 +: RAW];
        return d;
    endfunction

    logic [2:0]            state;
    logic                  last_read;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic [RAW-1:0]        idx_q;
    logic [DW-1:0]         wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  do_write;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DW-1:0]         rdata_q;

    dec_t aw_d;
    dec_t ar_d;
    logic idle;
    logic grant_w;
    logic grant_r;
    logic wr_hs;
    logic rd_hs;
    logic strb_nz;
    logic strb_full;
    logic w_err;
    logic w_rf;
    logic r_err;
    logic [DW-1:0] r_data;

    assign aw_d      = decode(s_axi.awaddr);
    assign ar_d      = decode(s_axi.araddr);
    assign strb_nz   = |s_axi.wstrb;
    assign strb_full = &s_axi.wstrb;

    // Alternate when both channels are ready; last_read resets high so a write goes first
    assign idle    = (state == IDLE) && !rst;
    assign grant_w = s_axi.awvalid && s_axi.wvalid && (!s_axi.arvalid || last_read);
    assign grant_r = s_axi.arvalid && !grant_w;
    assign wr_hs   = idle && grant_w;
    assign rd_hs   = idle && grant_r;

    assign s_axi.awready = wr_hs;
    assign s_axi.wready  = wr_hs;
    assign s_axi.arready = rd_hs;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    // In IDLE the regfile port follows the read address so read data is ready at the AR handshake
    assign regfile_addr         = (state == IDLE) ? ar_d.idx : idx_q;
    assign regfile_write_enable = (state == W_COMMIT) && do_write;
    assign regfile_write_data   = wdata_q;

    always_comb begin
        w_err = 1'b1;
        w_rf  = 1'b0;
        if (aw_d.csr) begin
            case (aw_d.sel)
                2'd0:    w_err = strb_nz && s_axi.wdata[2] && !cpu_halted;
                2'd3:    w_err = 1'b0;
                default: w_err = 1'b1;
            endcase
        end else if (aw_d.win) begin
            w_err = !cpu_halted;
            w_rf  = cpu_halted && strb_nz;
        end
    end

    always_comb begin
        r_err  = 1'b1;
        r_data = '0;
        if (ar_d.csr) begin
            r_err = 1'b0;
            case (ar_d.sel)
                2'd0:    r_data = {{(DW-1){1'b0}}, cpu_halt};
                2'd1:    r_data = {{(DW-1){1'b0}}, cpu_halted};
                2'd2:    r_data = cpu_pc;
                default: r_data = DW'(step_cnt);
            endcase
        end else if (ar_d.win && cpu_halted) begin
            r_err  = 1'b0;
            r_data = regfile_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_read <= 1'b1;
            step_cnt  <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            do_write  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            cpu_halt  <= 1'b0;
            cpu_step  <= 1'b0;
        end else begin
            cpu_step <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hs) begin
                        last_read <= 1'b0;
                        idx_q     <= aw_d.idx;
                        wdata_q   <= s_axi.wdata;
                        wstrb_q   <= s_axi.wstrb;
                        do_write  <= w_rf;
                        bresp_q   <= w_err ? RESP_SLVERR : RESP_OKAY;
                        state     <= (w_rf && !strb_full) ? W_MERGE : W_COMMIT;
                        if (aw_d.csr && !w_err && strb_nz) begin
                            if (aw_d.sel == 2'd0) begin
                                // HALT beats RESUME, and STEP suppresses RESUME
                                if (s_axi.wdata[0])
                                    cpu_halt <= 1'b1;
                                else if (s_axi.wdata[1] && !s_axi.wdata[2])
                                    cpu_halt <= 1'b0;
                                if (s_axi.wdata[2]) begin
                                    cpu_step <= 1'b1;
                                    if (step_cnt != '1)
                                        step_cnt <= step_cnt + 1'b1;
                                end
                            end else if (aw_d.sel == 2'd3) begin
                                step_cnt <= '0;
                            end
                        end
                    end else if (rd_hs) begin
                        last_read <= 1'b1;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_data;
                        rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
                        state     <= R_DATA;
                    end
                end
                W_MERGE: begin
                    for (int b = 0; b < STRB_W; b++)
                        if (!wstrb_q[b])
                            wdata_q[8*b +: 8] <= regfile_read_data[8*b +: 8];
                    state <= W_COMMIT;
                end
                W_COMMIT: begin
                    bvalid_q <= 1'b1;
                    state    <= B_RESP;
                end
                B_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
